// File: rtl/ram_req_ctrl_if.sv
// ram_req_ctrl_if: request/response channel between a requester and ram_req_ctrl.
//   req_valid/req_ready/req_we/req_addr/req_wdata : request handshake
//   rsp_valid/rsp_ready/rsp_rdata                 : read response handshake
// Modports: master = requester side, slave = controller side.
interface ram_req_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request/response front end for a DEPTH x DATA_W single-port RAM
// whose read port is a combinational read of a registered address.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ram_req_ctrl_if.slave (request and read-response handshakes)
//   ram_data, ram_addr, ram_we : drive the RAM input pins
//   ram_out    : RAM read data (for the address registered on the previous edge)
//   busy       : post-reset clear sequence in progress
// Optional feature: define RAM_REQ_CTRL_CLEAR_EN to zero-fill the whole RAM
// after reset (DEPTH cycles) before accepting requests.
module ram_req_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_req_ctrl_if.slave     bus,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("ram_req_ctrl: DEPTH must equal 2**ADDR_W");
  end

`ifdef RAM_REQ_CTRL_CLEAR_EN
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD_WAIT, S_RSP} state_t;
  localparam state_t RESET_STATE = S_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RSP} state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef RAM_REQ_CTRL_CLEAR_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_REQ_CTRL_CLEAR_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = bus.req_addr;
    ram_data    = bus.req_wdata;
`ifdef RAM_REQ_CTRL_CLEAR_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
`ifdef RAM_REQ_CTRL_CLEAR_EN
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        ram_data = '0;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
`endif
      S_IDLE: begin
        req_ready = 1'b1;
        // Writes land on the accepting edge; a read leaves ram_we low so the
        // RAM registers the address on that same edge.
        ram_we = bus.req_valid & bus.req_we;
        if (bus.req_valid && !bus.req_we) begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        rsp_rdata_d = ram_out;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef RAM_REQ_CTRL_CLEAR_EN
  assign busy = (state_q == S_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl with a behavioural registered-address
// RAM model. Expected read data comes from a shadow copy of written values and
// is queued when a read is accepted, then popped when the response retires.
module tb_ram_req_ctrl;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_req_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_out;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              busy;

  ram_req_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_out  (ram_out),
    .busy     (busy)
  );

  // 64x8 single-port RAM: write on edge, address registered, async read of it.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_reg;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    addr_reg <= ram_addr;
  end
  assign ram_out = mem[addr_reg];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] shadow [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; waits (bounded) for req_ready.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    wait_ready("wr_ready");
    check("wr_ram_we", {31'd0, ram_we}, 32'd1);
    check("wr_ram_addr", {26'd0, ram_addr}, {26'd0, a});
    shadow[a] = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int stall);
    logic [DATA_W-1:0] exp;
    exp = shadow[a];
    bus.rsp_ready = (stall == 0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    @(negedge clk);
    wait_ready("rd_ready");
    check("rd_ram_we", {31'd0, ram_we}, 32'd0);
    exp_q.push_back(exp);
    @(posedge clk); #1;                      // accept edge N
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rd_wait_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rd_wait_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;                      // edge N+1
    @(negedge clk);
    check("rd_latency", {31'd0, bus.rsp_valid}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_rdata", {24'd0, bus.rsp_rdata}, {24'd0, exp});
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("stall_ram_we", {31'd0, ram_we}, 32'd0);
      @(posedge clk); #1;
      if (i == stall - 1) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    check("rsp_queue", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) check("rsp_data", {24'd0, bus.rsp_rdata}, {24'd0, exp_q.pop_front()});
    @(posedge clk); #1;                      // handshake edge
    @(negedge clk);
    check("rsp_retired", {31'd0, bus.rsp_valid}, 32'd0);
    check("rsp_hold", {24'd0, bus.rsp_rdata}, {24'd0, exp});
    check("rsp_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Releases reset and waits out any clear sequence; returns at posedge+1.
  task automatic release_reset();
    int n = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
`ifdef RAM_REQ_CTRL_CLEAR_EN
    check("clr_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("clr_ram_we", {31'd0, ram_we}, 32'd1);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("clr_cycles", n, DEPTH);
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
`else
    check("busy_zero", {31'd0, busy}, 32'd0);
`endif
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Reset while a read is outstanding (in RD_WAIT or in RSP).
  task automatic reset_mid_read(input logic [ADDR_W-1:0] a, input bit in_rsp);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    @(negedge clk);
    wait_ready("mr_ready");
    exp_q.push_back(shadow[a]);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (in_rsp) begin
      @(posedge clk); #1;
      check("mr_pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mr_async_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    exp_q.delete();
    bus.rsp_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mr_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
`ifdef RAM_REQ_CTRL_CLEAR_EN
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
`else
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
`endif
    repeat (2) @(posedge clk);
    release_reset();

    // Top address write then read.
    do_write(6'h3F, 8'h5A);
    do_read(6'h3F, 0);

    // Back-to-back writes, one per cycle.
    c0 = cyc;
    do_write(6'h00, 8'h11);
    do_write(6'h01, 8'h22);
    do_write(6'h02, 8'h33);
    do_write(6'h3F, 8'h44);
    check("wr_throughput", cyc - c0, 32'd4);
    do_read(6'h00, 0);
    do_read(6'h01, 0);
    do_read(6'h02, 0);
    do_read(6'h3F, 0);

    // Back-pressured response.
    do_read(6'h00, 5);

    // Random write/read pairs.
    for (int i = 0; i < 6; i++) begin
      ra = 6'($urandom_range(0, DEPTH - 1));
      rd = 8'($urandom);
      do_write(ra, rd);
      do_read(ra, i % 3);
    end

`ifdef RAM_REQ_CTRL_CLEAR_EN
    // Clear after reset wipes a previously written word.
    do_write(6'h10, 8'hFF);
    #2 rst_n = 1'b0;
    release_reset();
    do_read(6'h10, 0);
`endif

    // Reset during RD_WAIT and during RSP.
    do_write(6'h05, 8'hC3);
    reset_mid_read(6'h05, 1'b0);
    do_write(6'h06, 8'h3C);
    reset_mid_read(6'h06, 1'b1);
    do_write(6'h07, 8'h96);
    do_read(6'h07, 0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_req_ctrl.md
# ram_req_ctrl

- Request/response front end placed directly upstream of the 64×8 single-port RAM.
- Accepts read and write requests over a valid/ready handshake and drives the RAM's data, address and write-enable pins.
- Holds off new requests while a read is outstanding, then captures the RAM's registered-address read data and returns it over a valid/ready response channel.
- Optionally zero-fills the whole RAM after reset before accepting traffic.

## Interface
Parameters:
- DATA_W, 8, data width; matches the RAM word.
- ADDR_W, 6, address width.
- DEPTH, 64, number of RAM words; equals 2**ADDR_W.

Ports:
- Reset scheme: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write request, 0 = read request.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read data available on rsp_rdata.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data.
- ram_data  out  DATA_W  to RAM data input.
- ram_addr  out  ADDR_W  to RAM address input.
- ram_we  out  1  to RAM write enable.
- ram_out  in  DATA_W  from RAM output (combinational read of the registered address).
- busy  out  1  clear sequence in progress.

## Operation
- States: CLEAR (only with the macro), IDLE, RD_WAIT, RSP.
- req_ready = (state == IDLE). A request is accepted on any edge where req_valid & req_ready.
- IDLE outputs:
  - ram_addr = req_addr, ram_data = req_wdata.
  - ram_we = req_valid & req_we (combinational), so a write lands on the accepting edge.
- IDLE transitions:
  - Accepted write: stay in IDLE. Writes produce no response.
  - Accepted read: ram_we = 0, so the RAM latches ram_addr into its address register on that edge; go to RD_WAIT.
- RD_WAIT: ram_we = 0. On the next edge: rsp_rdata <= ram_out, rsp_valid <= 1, go to RSP.
- RSP:
  - ram_we = 0; rsp_rdata and rsp_valid hold.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - rsp_rdata keeps its last value after the handshake.
- Outside IDLE and CLEAR: ram_we = 0, ram_addr = req_addr. The RAM address register may change; this is harmless because data is captured before RSP.
- Write to the address of a pending read cannot occur, since req_ready = 0 while a read is outstanding.
- Address 0 and address DEPTH-1 behave identically to any other address; no wrap or bounds logic on requests.

## Timing
- Reset values:
  - rsp_valid 0, rsp_rdata 0.
  - busy 1 with CLEAR_EN, else 0.
  - req_ready 0 with CLEAR_EN, else 1.
  - Internal counter 0.
- Reset state: CLEAR with CLEAR_EN, else IDLE.
- Write throughput: one per cycle, back-to-back.
- Read latency: accepted on edge N, rsp_valid high after edge N+1.
- Read throughput: minimum 3 cycles per read with rsp_ready held high (accept, RD_WAIT, RSP handshake).
- Reset mid-operation: any outstanding read or response is discarded; rsp_valid drops immediately (async).

## Configuration
- Macro: RAM_REQ_CTRL_CLEAR_EN.
- Defined:
  - After reset release, CLEAR writes 0 to addresses 0..DEPTH-1, one per cycle, using an ADDR_W-bit counter.
  - During CLEAR: ram_we = 1, ram_addr = counter, ram_data = 0, busy = 1, req_ready = 0.
  - On the edge that writes DEPTH-1: go to IDLE, busy <= 0, counter returns to 0.
  - Total duration is exactly DEPTH cycles; a reset during CLEAR restarts at address 0.
- Undefined: no CLEAR state or counter; busy is tied 0; RAM contents after reset are undefined.

## Test plan
- Write 0x5A to 0x3F, then read 0x3F with rsp_ready = 1 -> rsp_rdata = 0x5A, rsp_valid high exactly 1 cycle after read accept, for 1 cycle.
- Four back-to-back writes (0x00 <- 0x11, 0x01 <- 0x22, 0x02 <- 0x33, 0x3F <- 0x44), then read each -> req_ready stays 1 during the writes; reads return 0x11/0x22/0x33/0x44.
- Read 0x00 with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0, ram_we = 0 throughout; response retires on the first cycle rsp_ready = 1.
- With CLEAR_EN: pre-write 0xFF to 0x10, assert reset -> busy = 1 for exactly 64 cycles after release; then read 0x10 -> 0x00.
- Assert rst_n low during RD_WAIT -> rsp_valid = 0 immediately; after release, no stale response appears.
